uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx serializer among NUM_REQ byte producers. Arbitration is round-robin with frame locking:
//  a granted requester keeps the transmitter until it sends a byte tagged "last".
//  A watchdog recovers from a missing i_Tx_Done or from a requester that stalls mid-frame.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 48 ++++
 rtl/uart_tx_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: arbiter state encoding,
//   the watchdog multiplier (bit times per byte plus margin) and a small
//   elaboration-time helper.
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no owner, round-robin pick armed
    ST_WAIT = 2'd1,  // byte handed to uart_tx, waiting for its done pulse
    ST_GAP  = 2'd2,  // one clock for uart_tx cleanup
    ST_HOLD = 2'd3   // locked owner owes the next byte of its frame
  } arb_state_e;

  // Watchdog span in bit times: 10 bits on the wire plus two bits of margin.
  localparam int WD_MULT = 12;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker. Starting just after 'ptr' and
//   wrapping modulo N, returns the first asserted request.
// Ports
//   req     in   N    request vector
//   ptr     in   IW   index of the previous winner (lowest priority now)
//   onehot  out  N    one-hot winner, 0 when no request
//   index   out  IW   binary winner index, 0 when no request
//   any     out  1    at least one request asserted
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          any
);

  int            c;
  logic [IW-1:0] cidx;

  // Walk from the farthest candidate to the nearest so the nearest asserted
  // request after ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value held over from a previous evaluation (no latch).
    onehot = '0;
    index  = '0;
    c      = 0;
    cidx   = '0;
    for (int k = N; k >= 1; k--) begin
      c    = (int'(ptr) + k) % N;
      cidx = c[IW-1:0];
      if (req[cidx]) begin
        onehot       = '0;
        onehot[cidx] = 1'b1;
        index        = cidx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx serializer among NUM_REQ byte producers. Round-robin
//   arbitration with frame locking: the owner keeps the transmitter until it
//   sends a byte tagged last. A watchdog recovers from a missing i_Tx_Done
//   and from an owner that stalls between frame bytes; either sets the sticky
//   o_Err_Timeout flag.
// Ports
//   i_Clock        in   1          system clock, rising edge
//   i_Rst_n        in   1          asynchronous active-low reset
//   i_Req_Valid    in   NUM_REQ    requester r has a byte pending
//   i_Req_Byte     in   8*NUM_REQ  byte of requester r at [8r+7:8r]
//   i_Req_Last     in   NUM_REQ    byte of requester r ends its frame
//   o_Req_Ready    out  NUM_REQ    1-clk pulse, byte of requester r consumed
//   o_Grant        out  NUM_REQ    one-hot owner, 0 when idle
//   o_Tx_DV        out  1          1-clk start strobe to uart_tx
//   o_Tx_Byte      out  8          byte to uart_tx, held until next issue
//   i_Tx_Active    in   1          uart_tx busy
//   i_Tx_Done      in   1          uart_tx end-of-byte pulse
//   o_Busy         out  1          FSM not idle
//   o_Err_Timeout  out  1          sticky watchdog / hold expiry flag
// ----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 87,
  parameter int HOLD_MAX     = 1024
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Err_Timeout
);

  localparam int IW       = $clog2(NUM_REQ);
  localparam int WD_LIMIT = WD_MULT * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(max_int(WD_LIMIT, HOLD_MAX)) + 1;

  // Expiry fires on the clock whose increment would reach the limit, so the
  // flag lands exactly LIMIT clocks after the state was entered.
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(WD_LIMIT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [IW-1:0]    PTR_INIT  = IW'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               lock_q, lock_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               dv_q, dv_d;
  logic [7:0]         byte_q, byte_d;
  logic               busy_q;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req    (i_Req_Valid),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .any    (pick_any)
  );

  // Events shared by the next-state and output decoders.
  logic               issue_idle, issue_hold, issue;
  logic               wd_expire, hold_expire;
  logic [IW-1:0]      iss_idx;
  logic [NUM_REQ-1:0] iss_onehot;

  // Issue is withheld while uart_tx is still busy, so DV never overlaps it.
  assign issue_idle  = (state_q == ST_IDLE) && pick_any && !i_Tx_Active;
  // In HOLD only the owner is looked at; grant_q is its one-hot.
  assign issue_hold  = (state_q == ST_HOLD) && |(i_Req_Valid & grant_q) && !i_Tx_Active;
  assign issue       = issue_idle || issue_hold;
  assign wd_expire   = (state_q == ST_WAIT) && !i_Tx_Done && (cnt_q == WD_LAST);
  assign hold_expire = (state_q == ST_HOLD) && !issue_hold && (cnt_q == HOLD_LAST);
  assign iss_idx     = issue_idle ? pick_idx    : ptr_q;
  assign iss_onehot  = issue_idle ? pick_onehot : grant_q;

  // State register.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process evaluation order.
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (issue_idle) state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_Tx_Done)      state_d = ST_GAP;
        else if (wd_expire) state_d = ST_IDLE;
      end
      ST_GAP:  state_d = lock_q ? ST_IDLE : ST_HOLD;
      ST_HOLD: begin
        if (issue_hold)       state_d = ST_WAIT;
        else if (hold_expire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs and datapath.
  always_comb begin
    grant_d = grant_q;
    ready_d = '0;
    dv_d    = 1'b0;
    byte_d  = byte_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    err_d   = err_q;

    if (issue) begin
      grant_d = iss_onehot;
      ready_d = iss_onehot;
      dv_d    = 1'b1;
      byte_d  = i_Req_Byte[{iss_idx, 3'b000} +: 8];
      lock_d  = i_Req_Last[iss_idx];
      ptr_d   = iss_idx;
    end

    if (wd_expire || hold_expire) begin
      err_d   = 1'b1;
      grant_d = '0;
    end

    // End of a frame: the owner gives up the transmitter after the gap.
    if ((state_q == ST_GAP) && lock_q) begin
      grant_d = '0;
    end

    // One counter serves both timeouts; any state change restarts it.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_WAIT) || (state_q == ST_HOLD)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Registered outputs and datapath.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q   <= '0;
      ptr_q   <= PTR_INIT;
      lock_q  <= 1'b0;
      grant_q <= '0;
      ready_q <= '0;
      dv_q    <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      dv_q    <= dv_d;
      byte_q  <= byte_d;
      busy_q  <= (state_d != ST_IDLE);
      err_q   <= err_d;
    end
  end

  assign o_Grant       = grant_q;
  assign o_Req_Ready   = ready_q;
  assign o_Tx_DV       = dv_q;
  assign o_Tx_Byte     = byte_q;
  assign o_Busy        = busy_q;
  assign o_Err_Timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter with a behavioural uart_tx model
//   (10 bit times per byte). Requesters are fed from per-requester queues;
//   the expected (requester, byte) order is pushed to a scoreboard when the
//   stimulus is queued and compared at every o_Tx_DV.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int CLKS_PER_BIT = 87;
  localparam int HOLD_MAX     = 1024;
  localparam int WD_CLKS      = 12 * CLKS_PER_BIT;
  localparam int BYTE_CLKS    = 10 * CLKS_PER_BIT;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 o_Busy;
  logic                 o_Err_Timeout;

  // uart_tx model
  logic       mdl_active;
  logic       mdl_done;
  logic [7:0] mdl_byte;
  int         mdl_cnt;
  bit         mdl_mute    = 1'b0;
  bit         mdl_release = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         req;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] drv_q [NUM_REQ][$];  // {last, byte}

  always #50 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HOLD_MAX     (HOLD_MAX)
  ) dut (
    .i_Clock       (clk),
    .i_Rst_n       (rst_n),
    .i_Req_Valid   (req_valid),
    .i_Req_Byte    (req_byte),
    .i_Req_Last    (req_last),
    .o_Req_Ready   (o_Req_Ready),
    .o_Grant       (o_Grant),
    .o_Tx_DV       (o_Tx_DV),
    .o_Tx_Byte     (o_Tx_Byte),
    .i_Tx_Active   (mdl_active),
    .i_Tx_Done     (mdl_done),
    .o_Busy        (o_Busy),
    .o_Err_Timeout (o_Err_Timeout)
  );

  // Behavioural uart_tx: latches the byte on DV, stays active for one byte
  // time, then pulses done and drops active together. When muted it never
  // finishes until the bench releases it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_active <= 1'b0;
      mdl_done   <= 1'b0;
      mdl_cnt    <= 0;
      mdl_byte   <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (mdl_release) begin
        mdl_active <= 1'b0;
        mdl_cnt    <= 0;
      end else if (!mdl_active && o_Tx_DV) begin
        mdl_active <= 1'b1;
        mdl_cnt    <= 0;
        mdl_byte   <= o_Tx_Byte;
      end else if (mdl_active && !mdl_mute) begin
        if (mdl_cnt == BYTE_CLKS - 1) begin
          mdl_active <= 1'b0;
          mdl_done   <= 1'b1;
        end else begin
          mdl_cnt <= mdl_cnt + 1;
        end
      end
    end
  end

  // Requester driver: presents the head of each queue, pops on o_Req_Ready.
  initial begin
    logic [8:0] head;
    req_valid = '0;
    req_byte  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (o_Req_Ready[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
        if (drv_q[r].size() > 0) begin
          head             = drv_q[r][0];
          req_valid[r]     = 1'b1;
          req_byte[8*r+:8] = head[7:0];
          req_last[r]      = head[8];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t               e;
    logic [NUM_REQ-1:0] exp_oh;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (o_Tx_DV) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dv: got grant=%b byte=%h, required no issue", o_Grant, o_Tx_Byte);
          end else begin
            e = exp_q.pop_front();
            exp_oh = '0;
            exp_oh[e.req] = 1'b1;
            if (o_Grant !== exp_oh || o_Tx_Byte !== e.data || o_Req_Ready !== exp_oh) begin
              errors++;
              $display("FAIL issue: got grant=%b ready=%b byte=%h, required grant=%b ready=%b byte=%h",
                       o_Grant, o_Req_Ready, o_Tx_Byte, exp_oh, exp_oh, e.data);
            end
          end
          checks++;
          if (mdl_active !== 1'b0) begin
            errors++;
            $display("FAIL dv_while_active: got tx_active=%b at DV, required 0", mdl_active);
          end
        end else if (o_Req_Ready !== '0) begin
          checks++;
          errors++;
          $display("FAIL stray_ready: got ready=%b without DV, required 0", o_Req_Ready);
        end
        if (mdl_done) begin
          checks++;
          if (o_Tx_Byte !== mdl_byte) begin
            errors++;
            $display("FAIL byte_stable: got byte=%h at done, required %h", o_Tx_Byte, mdl_byte);
          end
        end
      end
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #(100 * 90000);
    $display("FAIL global_timeout: got no finish, required finish within 90000 clocks");
    $fatal(1, "time limit");
  end

  function automatic bit drv_empty();
    for (int r = 0; r < NUM_REQ; r++) if (drv_q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_stim();
    for (int r = 0; r < NUM_REQ; r++) drv_q[r].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_stim();
    mdl_mute    = 1'b0;
    mdl_release = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !o_Busy && drv_empty()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int r, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Grant[r] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_dv(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_Tx_DV === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mdl_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic last, input bit expect_now);
    drv_q[r].push_back({last, b});
    if (expect_now) exp_q.push_back('{req: r, data: b});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err_Timeout} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got grant=%b ready=%b dv=%b byte=%h busy=%b err=%b, required all 0",
               o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err_Timeout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_Grant, o_Tx_DV, o_Busy, o_Err_Timeout} !== '0) begin
      errors++;
      $display("FAIL reset_release: got grant=%b dv=%b busy=%b err=%b, required all 0",
               o_Grant, o_Tx_DV, o_Busy, o_Err_Timeout);
    end
  endtask

  task automatic test_single();
    bit ok;
    push(0, 8'h2F, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (o_Tx_DV !== 1'b1 || o_Req_Ready !== 4'b0001) begin
      errors++;
      $display("FAIL dv_latency: got dv=%b ready=%b one clock after valid, required dv=1 ready=0001",
               o_Tx_DV, o_Req_Ready);
    end
    wait_done(2 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done: got no tx done, required done within %0d clocks", 2 * BYTE_CLKS);
    end
    @(negedge clk);
    checks++;
    if (o_Grant !== 4'b0001 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_grant: got grant=%b busy=%b in gap, required grant=0001 busy=1", o_Grant, o_Busy);
    end
    @(negedge clk);
    checks++;
    if (o_Grant !== 4'b0000 || o_Busy !== 1'b0 || o_Err_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL release_after_gap: got grant=%b busy=%b err=%b, required 0000 0 0",
               o_Grant, o_Busy, o_Err_Timeout);
    end
  endtask

  task automatic test_two();
    bit ok;
    do_reset();
    push(1, 8'hA1, 1'b1, 1'b1);
    push(3, 8'hB3, 1'b1, 1'b1);
    wait_idle(4 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL two_drain: got %0d expected bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_round();
    bit ok;
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) push(r, 8'h40 + 8'(r), 1'b1, 1'b1);
    for (int r = 0; r < NUM_REQ; r++) push(r, 8'h50 + 8'(r), 1'b1, 1'b1);
    wait_idle(10 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL round_drain: got %0d expected bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_frame();
    bit ok;
    do_reset();
    push(2, 8'h10, 1'b0, 1'b1);
    push(2, 8'h11, 1'b0, 1'b1);
    push(2, 8'h12, 1'b1, 1'b1);
    wait_grant(2, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL frame_grant: got grant=%b, required 0100", o_Grant);
    end
    push(0, 8'h77, 1'b1, 1'b1);
    wait_idle(6 * BYTE_CLKS, ok);
    checks++;
    if (!ok || o_Err_Timeout !== 1'b0) begin
      errors++;
      $display("FAIL frame_drain: got outstanding=%0d err=%b, required 0 and 0", exp_q.size(), o_Err_Timeout);
    end
  endtask

  task automatic test_hold_timeout();
    bit ok;
    do_reset();
    push(2, 8'h5A, 1'b0, 1'b1);
    wait_grant(2, 20, ok);
    push(1, 8'hC1, 1'b1, 1'b1);
    wait_done(2 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hold_done: got no tx done, required done within %0d clocks", 2 * BYTE_CLKS);
    end
    repeat (HOLD_MAX + 1) @(negedge clk);
    checks++;
    if (o_Err_Timeout !== 1'b0 || o_Grant !== 4'b0100) begin
      errors++;
      $display("FAIL hold_early: got err=%b grant=%b before expiry, required err=0 grant=0100",
               o_Err_Timeout, o_Grant);
    end
    @(negedge clk);
    checks++;
    if (o_Err_Timeout !== 1'b1 || o_Grant !== 4'b0000) begin
      errors++;
      $display("FAIL hold_expiry: got err=%b grant=%b, required err=1 grant=0000", o_Err_Timeout, o_Grant);
    end
    wait_idle(3 * BYTE_CLKS, ok);
    checks++;
    if (!ok || o_Err_Timeout !== 1'b1) begin
      errors++;
      $display("FAIL hold_recover: got outstanding=%0d err=%b, required 0 and sticky 1",
               exp_q.size(), o_Err_Timeout);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    mdl_mute = 1'b1;
    push(0, 8'h3C, 1'b1, 1'b1);
    wait_dv(20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wd_dv: got no DV, required DV within 20 clocks");
    end
    repeat (WD_CLKS - 1) @(negedge clk);
    checks++;
    if (o_Err_Timeout !== 1'b0 || o_Busy !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: got err=%b busy=%b before expiry, required err=0 busy=1", o_Err_Timeout, o_Busy);
    end
    @(negedge clk);
    checks++;
    if (o_Err_Timeout !== 1'b1 || o_Grant !== 4'b0000 || o_Busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_expiry: got err=%b grant=%b busy=%b, required 1 0000 0",
               o_Err_Timeout, o_Grant, o_Busy);
    end
    // uart_tx is still stuck active: a new request must be deferred.
    push(1, 8'h99, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (o_Busy !== 1'b0 || o_Grant !== 4'b0000) begin
      errors++;
      $display("FAIL defer_active: got busy=%b grant=%b while tx active, required 0 0000", o_Busy, o_Grant);
    end
    exp_q.push_back('{req: 1, data: 8'h99});
    mdl_release = 1'b1;
    @(negedge clk);
    mdl_release = 1'b0;
    mdl_mute    = 1'b0;
    wait_idle(3 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wd_recover: got %0d expected bytes outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    push(2, 8'hE2, 1'b1, 1'b1);
    wait_dv(20, ok);
    repeat (5) @(negedge clk);
    #20;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err_Timeout} !== '0) begin
      errors++;
      $display("FAIL reset_async: got grant=%b ready=%b dv=%b byte=%h busy=%b err=%b, required all 0",
               o_Grant, o_Req_Ready, o_Tx_DV, o_Tx_Byte, o_Busy, o_Err_Timeout);
    end
    clear_stim();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(3, 8'h3D, 1'b1, 1'b0);
    push(0, 8'h0D, 1'b1, 1'b0);
    exp_q.push_back('{req: 0, data: 8'h0D});
    exp_q.push_back('{req: 3, data: 8'h3D});
    wait_idle(4 * BYTE_CLKS, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_mid_drain: got %0d expected bytes outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_two();
    test_round();
    test_frame();
    test_hold_timeout();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
